conv3x3_prog: RTL

Programmable, pipelined 3x3 convolution stage for the VGA video path, generalising the fixed Gaussian blur to any signed 3x3 kernel across a configurable number of colour channels. Sits inline between the pixel source and the display/next filter and carries the active-low VS/HS/blank syncs through with matching delay. Coefficients, normalising shift and output mode are written through a register port into shadow storage and take effect only at a frame boundary, so no frame ever mixes two kernels.

---
 rtl/conv3x3_prog.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_prog.sv
// Programmable pipelined 3x3 convolution for the VGA path; syncs travel with the pixel.
// Kernel, shift and mode are staged in shadow registers and committed on a vs_ni rising edge.
module conv3x3_prog #(
   parameter int LINE_WIDTH   = 640,
   parameter int PIXEL_DEPTH  = 8,
   parameter int CHANNELS     = 3,
   parameter int KERNEL_WIDTH = 4,
   localparam int SUM_WIDTH   = PIXEL_DEPTH + 1 + KERNEL_WIDTH + 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            vs_ni,
   input  logic                            hs_ni,
   input  logic                            blank_ni,
   input  logic [CHANNELS*PIXEL_DEPTH-1:0] pixel_i,
   input  logic                            cfg_we,
   input  logic [3:0]                      cfg_addr,
   input  logic [7:0]                      cfg_data,
   output logic                            cfg_pending,
   output logic                            vs_no,
   output logic                            hs_no,
   output logic                            blank_no,
   output logic [CHANNELS*PIXEL_DEPTH-1:0] pixel_o
);
   localparam int PW  = CHANNELS * PIXEL_DEPTH;
   localparam int DW  = PW + 3;
   localparam int SHW = $clog2(SUM_WIDTH);
   localparam int AW  = $clog2(LINE_WIDTH);
   localparam int WW  = $clog2(LINE_WIDTH + 5) + 1;
   localparam logic signed [SUM_WIDTH-1:0] PIX_MAX = SUM_WIDTH'((1 << PIXEL_DEPTH) - 1);

   logic [DW-1:0] w_din;
   logic [DW-1:0] r_lb1 [LINE_WIDTH];
   logic [DW-1:0] r_lb2 [LINE_WIDTH-1];
   logic [AW-1:0] r_ptr1, r_ptr2;
   logic [DW-1:0] r_rd1, r_rd2;
   logic [DW-1:0] r_w00;
   logic [DW-1:0] r_wsh [3][2];
   logic [DW-1:0] w_win [3][3];

   logic signed [KERNEL_WIDTH-1:0] r_sh_coef [9];
   logic signed [KERNEL_WIDTH-1:0] r_coef [9];
   logic signed [KERNEL_WIDTH-1:0] w_sh_coef_next [9];
   logic [SHW-1:0] r_sh_shift, r_shift, w_sh_shift_next;
   logic r_sh_mode, r_mode, w_sh_mode_next;
   logic r_vs_prev, w_commit, w_cfg_wr;
   logic w_unused;

   logic signed [SUM_WIDTH-1:0] w_prod [CHANNELS][9];
   logic signed [SUM_WIDTH-1:0] r_prod [CHANNELS][9];
   logic [SHW-1:0] r_s1_shift, r_s2_shift;
   logic r_s1_mode, r_s2_mode;
   logic [2:0] r_s1_sync, r_s2_sync;
   logic signed [SUM_WIDTH-1:0] w_round;
   logic signed [SUM_WIDTH-1:0] w_acc [CHANNELS];
   logic signed [SUM_WIDTH-1:0] r_s2_sum [CHANNELS];
   logic signed [SUM_WIDTH-1:0] w_val [CHANNELS];
   logic [PW-1:0] w_pix_out;

   logic [WW-1:0] r_warm;
   logic w_live;

   assign w_din    = {vs_ni, hs_ni, blank_ni, pixel_i};
   assign w_unused = &{1'b0, cfg_data};

   // Line buffers: read-before-write, so the read register already carries the extra clock of w[r][0].
   // The second buffer is fed from w[1][0], hence one entry shorter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr1 <= '0;
         r_ptr2 <= '0;
      end else begin
         r_ptr1 <= (r_ptr1 == AW'(LINE_WIDTH - 1)) ? '0 : r_ptr1 + AW'(1);
         r_ptr2 <= (r_ptr2 == AW'(LINE_WIDTH - 2)) ? '0 : r_ptr2 + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      r_rd1         <= r_lb1[r_ptr1];
      r_lb1[r_ptr1] <= w_din;
      r_rd2         <= r_lb2[r_ptr2];
      r_lb2[r_ptr2] <= r_rd1;
   end

   assign w_win[0][0] = r_w00;
   assign w_win[1][0] = r_rd1;
   assign w_win[2][0] = r_rd2;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_row
         assign w_win[gi][1] = r_wsh[gi][0];
         assign w_win[gi][2] = r_wsh[gi][1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      r_w00 <= w_din;
      for (int r = 0; r < 3; r++) begin
         r_wsh[r][0] <= w_win[r][0];
         r_wsh[r][1] <= r_wsh[r][0];
      end
   end

   assign w_cfg_wr = cfg_we && (cfg_addr <= 4'd10);
   assign w_commit = vs_ni && !r_vs_prev;

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         w_sh_coef_next[k] = r_sh_coef[k];
         if (cfg_we && cfg_addr == 4'(k))
            w_sh_coef_next[k] = cfg_data[KERNEL_WIDTH-1:0];
      end
      w_sh_shift_next = r_sh_shift;
      if (cfg_we && cfg_addr == 4'd9)
         w_sh_shift_next = cfg_data[SHW-1:0];
      w_sh_mode_next = r_sh_mode;
      if (cfg_we && cfg_addr == 4'd10)
         w_sh_mode_next = cfg_data[0];
   end

   // Commit uses the shadow's next value so a write landing on the commit cycle is included.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) begin
            r_sh_coef[k] <= (k == 4) ? KERNEL_WIDTH'(4) : ((k % 2) == 1) ? KERNEL_WIDTH'(2) : KERNEL_WIDTH'(1);
            r_coef[k]    <= (k == 4) ? KERNEL_WIDTH'(4) : ((k % 2) == 1) ? KERNEL_WIDTH'(2) : KERNEL_WIDTH'(1);
         end
         r_sh_shift  <= SHW'(4);
         r_shift     <= SHW'(4);
         r_sh_mode   <= 1'b0;
         r_mode      <= 1'b0;
         r_vs_prev   <= 1'b1;
         cfg_pending <= 1'b0;
      end else begin
         r_vs_prev <= vs_ni;
         for (int k = 0; k < 9; k++)
            r_sh_coef[k] <= w_sh_coef_next[k];
         r_sh_shift <= w_sh_shift_next;
         r_sh_mode  <= w_sh_mode_next;
         if (w_commit) begin
            for (int k = 0; k < 9; k++)
               r_coef[k] <= w_sh_coef_next[k];
            r_shift     <= w_sh_shift_next;
            r_mode      <= w_sh_mode_next;
            cfg_pending <= 1'b0;
         end else if (w_cfg_wr) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         for (genvar gk = 0; gk < 9; gk++) begin : g_tap
            logic signed [PIXEL_DEPTH:0] w_pix_s;
            assign w_pix_s = {1'b0, w_win[gk / 3][gk % 3][gi*PIXEL_DEPTH +: PIXEL_DEPTH]};
            assign w_prod[gi][gk] = SUM_WIDTH'(r_coef[gk]) * SUM_WIDTH'(w_pix_s);
         end
      end
   endgenerate

   // Shift and mode ride along with the products so a frame never mixes settings mid-pipeline.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < 9; k++)
            r_prod[c][k] <= w_prod[c][k];
      r_s1_shift <= r_shift;
      r_s1_mode  <= r_mode;
      r_s1_sync  <= w_win[1][1][DW-1 -: 3];
   end

   always_comb begin
      w_round = '0;
      if (r_s1_shift != '0)
         w_round = SUM_WIDTH'(1) << (r_s1_shift - SHW'(1));
      for (int c = 0; c < CHANNELS; c++) begin
         w_acc[c] = w_round;
         for (int k = 0; k < 9; k++)
            w_acc[c] = w_acc[c] + r_prod[c][k];
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++)
         r_s2_sum[c] <= w_acc[c];
      r_s2_shift <= r_s1_shift;
      r_s2_mode  <= r_s1_mode;
      r_s2_sync  <= r_s1_sync;
   end

   always_comb begin
      w_pix_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_val[c] = r_s2_sum[c] >>> r_s2_shift;
         if (r_s2_mode && w_val[c][SUM_WIDTH-1])
            w_val[c] = -w_val[c];
         if (w_val[c][SUM_WIDTH-1])
            w_pix_out[c*PIXEL_DEPTH +: PIXEL_DEPTH] = '0;
         else if (w_val[c] > PIX_MAX)
            w_pix_out[c*PIXEL_DEPTH +: PIXEL_DEPTH] = '1;
         else
            w_pix_out[c*PIXEL_DEPTH +: PIXEL_DEPTH] = w_val[c][PIXEL_DEPTH-1:0];
      end
   end

   // Warm-up hides stale line-buffer contents until the first fresh sample reaches the output.
   assign w_live = (r_warm == WW'(LINE_WIDTH + 4));

   always_ff @(posedge clk) begin
      if (reset)
         r_warm <= '0;
      else if (!w_live)
         r_warm <= r_warm + WW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || !w_live) begin
         vs_no    <= 1'b1;
         hs_no    <= 1'b1;
         blank_no <= 1'b0;
         pixel_o  <= '0;
      end else begin
         {vs_no, hs_no, blank_no} <= r_s2_sync;
         pixel_o <= r_s2_sync[0] ? w_pix_out : '0;
      end
   end
endmodule
